// File: rtl/colour_scan_if.sv
// Handshake and sensor bundle for the colour scan scheduler.
// slave = scheduler side, master = driver/consumer side.
interface colour_scan_if #(
  parameter int CW = 20
);
  logic          start;
  logic          continuous;
  logic          colour_freq;
  logic          s2;
  logic          s3;
  logic          busy;
  logic          res_valid;
  logic          res_ready;
  logic [CW-1:0] res_red;
  logic [CW-1:0] res_blue;
  logic [CW-1:0] res_clear;
  logic [CW-1:0] res_green;

  modport slave (
    input  start, continuous, colour_freq, res_ready,
    output s2, s3, busy, res_valid, res_red, res_blue, res_clear, res_green
  );

  modport master (
    output start, continuous, colour_freq, res_ready,
    input  s2, s3, busy, res_valid, res_red, res_blue, res_clear, res_green
  );
endinterface

// File: rtl/colour_scan_scheduler.sv
// Steps a colour sensor through RED/BLUE/CLEAR/GREEN, counting synchronised
// rising edges of its frequency output in a fixed window per filter.
//
// state   | meaning
// IDLE    | filters at RED, waiting for start or continuous
// SETTLE  | filter for ch driven, SETTLE_CYC cycles, edges ignored
// MEASURE | WINDOW_CYC cycles counting rising edges for ch
// PUBLISH | res_valid high, results and GREEN filter held until accepted
module colour_scan_scheduler #(
  parameter int SETTLE_CYC = 1000,
  parameter int WINDOW_CYC = 1000000,
  parameter int CW         = 20
) (
  input  logic          clk,
  input  logic          rst_n,
  colour_scan_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETTLE  = 2'd1,
    MEASURE = 2'd2,
    PUBLISH = 2'd3
  } state_t;

  // One timer serves both SETTLE and MEASURE; it only needs to reach max-1.
  localparam int TMAX = (SETTLE_CYC > WINDOW_CYC) ? SETTLE_CYC : WINDOW_CYC;
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
  localparam logic [TW-1:0] SETTLE_LAST = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] WINDOW_LAST = TW'(WINDOW_CYC - 1);
  localparam logic [CW-1:0] CNT_MAX     = '1;

  state_t        state_q;
  logic [1:0]    ch_q;
  logic [TW-1:0] tmr_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic [CW-1:0] red_q;
  logic [CW-1:0] blue_q;
  logic [CW-1:0] clear_q;
  logic [CW-1:0] green_q;
  logic          s2_q;
  logic          s3_q;
  logic          busy_q;
  logic          valid_q;
  logic [2:0]    sync_q;
  logic          rise;

  // sync_q[1] is the synchronised level, sync_q[2] its previous value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], bus.colour_freq};
    end
  end

  assign rise = sync_q[1] & ~sync_q[2];

  // Saturating count including this cycle's edge, so the last window cycle counts.
  always_comb begin
    cnt_d = cnt_q;
    if (rise && (cnt_q != CNT_MAX)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      red_q   <= '0;
      blue_q  <= '0;
      clear_q <= '0;
      green_q <= '0;
      s2_q    <= 1'b0;
      s3_q    <= 1'b0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          ch_q  <= '0;
          tmr_q <= '0;
          cnt_q <= '0;
          s2_q  <= 1'b0;
          s3_q  <= 1'b0;
          if (bus.start || bus.continuous) begin
            state_q <= SETTLE;
            busy_q  <= 1'b1;
          end
        end

        SETTLE: begin
          if (tmr_q == SETTLE_LAST) begin
            tmr_q   <= '0;
            state_q <= MEASURE;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end

        MEASURE: begin
          if (tmr_q == WINDOW_LAST) begin
            tmr_q <= '0;
            cnt_q <= '0;
            case (ch_q)
              2'd0:    red_q   <= cnt_d;
              2'd1:    blue_q  <= cnt_d;
              2'd2:    clear_q <= cnt_d;
              default: green_q <= cnt_d;
            endcase
            if (ch_q == 2'd3) begin
              state_q <= PUBLISH;
              valid_q <= 1'b1;
            end else begin
              ch_q    <= ch_q + 1'b1;
              {s2_q, s3_q} <= ch_q + 1'b1;
              state_q <= SETTLE;
            end
          end else begin
            tmr_q <= tmr_q + 1'b1;
            cnt_q <= cnt_d;
          end
        end

        PUBLISH: begin
          if (valid_q && bus.res_ready) begin
            valid_q <= 1'b0;
            ch_q    <= '0;
            s2_q    <= 1'b0;
            s3_q    <= 1'b0;
            if (bus.continuous) begin
              state_q <= SETTLE;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s2        = s2_q;
  assign bus.s3        = s3_q;
  assign bus.busy      = busy_q;
  assign bus.res_valid = valid_q;
  assign bus.res_red   = red_q;
  assign bus.res_blue  = blue_q;
  assign bus.res_clear = clear_q;
  assign bus.res_green = green_q;

endmodule

// File: doc/colour_scan_scheduler.md
COLOUR_SCAN_SCHEDULER -- requirements
Module: colour_scan_scheduler

Interface
REQ-001 SHALL have parameter SETTLE_CYC, default 1000: cycles to wait after each filter change before counting.
REQ-002 SHALL have parameter WINDOW_CYC, default 1000000: length in cycles of each per-filter counting window.
REQ-003 SHALL have parameter CW, default 20: width of each result counter.
REQ-004 SHALL have port clk, input, 1: single system clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, asynchronous and active-low.
REQ-006 SHALL have port start, input, 1: one-cycle request for a scan.
REQ-007 SHALL have port continuous, input, 1: when high, a new scan starts automatically after each accepted result.
REQ-008 SHALL have port colour_freq, input, 1: asynchronous sensor output square wave.
REQ-009 SHALL have ports s2 and s3, output, 1 each: sensor filter select.
REQ-010 SHALL have port busy, output, 1: high whenever the FSM is not in IDLE.
REQ-011 SHALL have port res_valid, output, 1: result set available.
REQ-012 SHALL have port res_ready, input, 1: consumer accepts the result set.
REQ-013 SHALL have ports res_red, res_blue, res_clear and res_green, output, CW each: rising-edge counts per filter.

Function
REQ-014 SHALL pass colour_freq through a 2-flop synchroniser.
- A rising edge is sync2 high while a third flop is low.
REQ-015 SHALL use the filter order RED(s2=0,s3=0), BLUE(0,1), CLEAR(1,0), GREEN(1,1).
REQ-016 SHALL implement the FSM states IDLE, SETTLE, MEASURE and PUBLISH, plus a 2-bit channel index ch.
REQ-017 IDLE SHALL behave as follows.
- s2=s3=0 and ch=0.
- start=1, or continuous=1, moves the FSM to SETTLE on the next cycle.
REQ-018 SETTLE SHALL drive s2/s3 for ch and last exactly SETTLE_CYC cycles, then go to MEASURE.
- Edges in SETTLE SHALL NOT be counted.
REQ-019 MEASURE SHALL last exactly WINDOW_CYC cycles and count detected rising edges, including an edge on the final cycle.
REQ-020 The count SHALL saturate at 2^CW-1 and never wrap.
REQ-021 On the final MEASURE cycle, the count SHALL be written to the register for ch and the working counter cleared.
- If ch<3: increment ch and go to SETTLE.
- If ch=3: go to PUBLISH.
REQ-022 PUBLISH SHALL behave as follows.
- res_valid=1, with all four results stable and s2/s3 held at GREEN.
- On res_valid&res_ready: go to SETTLE with ch=0 if continuous=1, else to IDLE.
- res_valid deasserts on the following cycle.
REQ-023 Scan latency SHALL be 1 + 4*(SETTLE_CYC+WINDOW_CYC) cycles from the start sample to res_valid=1.
REQ-024 start SHALL be ignored while busy=1, with no restart and no queueing.
REQ-025 continuous deasserted mid-scan SHALL let the current scan finish and publish, then return to IDLE after acceptance.
REQ-026 res_ready asserted while res_valid=0 SHALL have no effect.
REQ-027 Result registers SHALL change only in MEASURE final cycles.
- They hold their value through IDLE and PUBLISH.
REQ-028 Counter widths SHALL be sized for SETTLE_CYC and WINDOW_CYC.
- Timers SHALL count from 0 and compare against value-1, with no off-by-one.

Reset
REQ-029 When rst_n=0, the block SHALL immediately enter IDLE.
- busy=0, res_valid=0, s2=0, s3=0, ch=0.
- All result registers, the working counter, the timers and the synchroniser flops SHALL be 0.
REQ-030 A reset asserted mid-scan SHALL discard partial counts.
- After release, the block stays in IDLE until start=1 or continuous=1.

Verification
All scenarios use SETTLE_CYC=4, WINDOW_CYC=100, CW=20.
REQ-031 Single scan:
- Stimulus: start pulse; colour_freq period 10/20/25/50 cycles during RED/BLUE/CLEAR/GREEN.
- Response: res_valid after 417 cycles; res_red=10±1, res_blue=5±1, res_clear=4±1, res_green=2±1; s2/s3 sequence 00,01,10,11.
REQ-032 Backpressure:
- Stimulus: hold res_ready=0 for 50 cycles after res_valid.
- Response: res_valid and all results stable for 50 cycles; IDLE one cycle after res_ready=1.
REQ-033 Continuous mode:
- Stimulus: continuous=1 with res_ready=1.
- Response: back-to-back scans, the next SETTLE starting the cycle after acceptance; busy never drops.
REQ-034 Ignored start:
- Stimulus: start pulse at cycle 200 of a scan.
- Response: exactly one publish, with latency unchanged.
REQ-035 Saturation:
- Stimulus: CW=3 and colour_freq period 2 cycles.
- Response: all results = 7, no wrap.
REQ-036 Reset mid-scan:
- Stimulus: rst_n=0 during BLUE MEASURE.
- Response: outputs 0 immediately; no res_valid until a new start is given.
